// File: rtl/l2_mem_resp_pkg.sv
// l2_mem_resp_pkg
// Shared definitions for the L2 main-memory responder: line/address widths,
// the responder FSM state encoding and the latency-counter width helper.
package l2_mem_resp_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // The counter is loaded with LATENCY-1 and must hold that value; a
    // minimum of one bit keeps the vector legal when LATENCY is 1 or 2.
    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/l2_mem_resp_ram.sv
// l2_mem_resp_ram
// Single-port synchronous backing store of 2^IDX_W lines with a registered
// read port. The read register is the responder's mem_rdata: it only loads
// when a read is issued, so it holds the last read line between transactions,
// and it resets to zero. The array itself is never reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (read register only)
//   i_we     in   write enable
//   i_re     in   read enable (loads o_rdata at the next edge)
//   i_idx    in   line index
//   i_wdata  in   write line
//   o_rdata  out  registered read line
module l2_mem_resp_ram
    import l2_mem_resp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [2**IDX_W];
    logic [LINE_W-1:0] r_rdata;

    // Array write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Registered read; holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= {LINE_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// l2_mem_responder
// Line-granular main-memory responder for the L2 data cache. Accepts one
// mem_read or mem_write at a time, answers after LATENCY cycles with a
// one-cycle mem_ready pulse, then spends one HOLD cycle ignoring the request
// lines (the cache is still driving them while it samples mem_ready).
//
// Optional feature macro: L2_MEM_RESP_STATS_EN adds the rd_cnt/wr_cnt
// completed-transaction counters and their ports.
//
// Ports:
//   clk           in   clock, rising edge
//   proc_reset_n  in   asynchronous active-low reset
//   mem_read      in   read request, held until completion
//   mem_write     in   write request, held until completion
//   mem_addr      in   line address; low IDX_W bits index the store
//   mem_wdata     in   write line
//   mem_rdata     out  read line (valid in the ready cycle and the one after)
//   mem_ready     out  one-cycle completion pulse
//   proto_err     out  sticky: read and write seen together while idle
//   rd_cnt        out  completed reads  (L2_MEM_RESP_STATS_EN only)
//   wr_cnt        out  completed writes (L2_MEM_RESP_STATS_EN only)
module l2_mem_responder
    import l2_mem_resp_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err
`ifdef L2_MEM_RESP_STATS_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
`endif
);

    localparam int              CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               r_op_write;
    logic [IDX_W-1:0]   r_idx;
    logic [LINE_W-1:0]  r_wdata;
    logic               r_mem_ready;
    logic               r_proto_err;

    logic               w_accept;
    logic               w_both;
    logic               w_req_held;
    logic               w_ram_we;
    logic               w_ram_re;
    logic [IDX_W-1:0]   w_ram_idx;

    // Upper address bits alias onto the store and are deliberately unused.
    logic               w_unused_addr;
    assign w_unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

    // Next-state, counter and RAM-control decode.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_both       = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;
        w_ram_idx    = r_idx;
        w_req_held   = r_op_write ? mem_write : mem_read;

        case (r_state)
            ST_IDLE: begin
                // On acceptance the latched index is not yet available, so
                // the RAM is addressed straight from the bus (LATENCY=1 read).
                w_ram_idx = mem_addr[IDX_W-1:0];
                if (mem_read && mem_write) begin
                    w_both = 1'b1;
                end else if (mem_read || mem_write) begin
                    w_accept   = 1'b1;
                    w_next_cnt = CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_next_state = ST_DONE;
                        w_ram_re     = mem_read;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!w_req_held) begin
                    // Cache withdrew the request: abandon without side effects.
                    w_next_state = ST_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    // Last busy cycle: issue the read so the registered RAM
                    // output is valid in DONE.
                    w_next_state = ST_DONE;
                    w_next_cnt   = {CNT_W{1'b0}};
                    w_ram_re     = !r_op_write;
                end else begin
                    w_next_cnt = r_cnt - CNT_ONE;
                end
            end
            ST_DONE: begin
                w_ram_we     = r_op_write;
                w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, counter, ready pulse and sticky protocol-error registers.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_mem_ready <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_mem_ready <= (w_next_state == ST_DONE);
            r_proto_err <= r_proto_err | w_both;
        end
    end

    // Request latch: op, index and write line captured at acceptance.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_op_write <= 1'b0;
            r_idx      <= {IDX_W{1'b0}};
            r_wdata    <= {LINE_W{1'b0}};
        end else if (w_accept) begin
            r_op_write <= mem_write;
            r_idx      <= mem_addr[IDX_W-1:0];
            r_wdata    <= mem_wdata;
        end else begin
            r_op_write <= r_op_write;
            r_idx      <= r_idx;
            r_wdata    <= r_wdata;
        end
    end

    l2_mem_resp_ram #(
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (proc_reset_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_idx   (w_ram_idx),
        .i_wdata (r_wdata),
        .o_rdata (mem_rdata)
    );

    assign mem_ready = r_mem_ready;
    assign proto_err = r_proto_err;

`ifdef L2_MEM_RESP_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    // Completed-transaction counters; aborts never reach DONE.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (r_state == ST_DONE) begin
            if (r_op_write) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
                r_rd_cnt <= r_rd_cnt;
            end else begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
                r_wr_cnt <= r_wr_cnt;
            end
        end else begin
            r_rd_cnt <= r_rd_cnt;
            r_wr_cnt <= r_wr_cnt;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder
// Directed + randomized bench for l2_mem_responder. A line-array model of the
// store plus a "last read line" and transaction counts give every expected
// value; the request/response protocol is driven like the L2 cache does it.
module tb_l2_mem_responder;

    localparam int LAT   = 4;
    localparam int IDXW  = 10;
    localparam int DEPTH = 1 << IDXW;

    logic         clk;
    logic         proc_reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;
`ifdef L2_MEM_RESP_STATS_EN
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;
`endif

    l2_mem_responder #(
        .LATENCY (LAT),
        .IDX_W   (IDXW)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .proto_err    (proto_err)
`ifdef L2_MEM_RESP_STATS_EN
        ,
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model.
    logic [127:0] model_mem [DEPTH];
    logic [127:0] model_rdata;
    int           model_rd;
    int           model_wr;
    int           written_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef L2_MEM_RESP_STATS_EN
        check({tag, "_rd_cnt"}, 128'(rd_cnt), 128'(model_rd));
        check({tag, "_wr_cnt"}, 128'(wr_cnt), 128'(model_wr));
`else
        if (tag.len() == 0) $display("counters absent");
`endif
    endtask

    // Watch the idle bus for a number of cycles; no pulse may appear.
    task automatic idle_watch(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mem_ready) pulses++;
        end
        check({tag, "_no_pulse"}, 128'(pulses), 128'(0));
    endtask

    // One complete cache-style transaction: request held until the cycle
    // after mem_ready (HOLD), released at the start of the following cycle.
    task automatic xact(input bit is_write, input logic [27:0] addr,
                        input logic [127:0] data, input string tag);
        int n;
        bit got;
        int idx;
        idx       = int'(addr[IDXW-1:0]);
        mem_addr  = addr;
        mem_wdata = data;
        mem_read  = !is_write;
        mem_write = is_write;
        n   = 0;
        got = 1'b0;
        while (!got && n < LAT + 8) begin
            tick();
            n++;
            if (n == 1) begin
                // Bus contents after acceptance must not matter.
                mem_addr  = 28'($urandom);
                mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_ready) got = 1'b1;
        end
        check({tag, "_latency"}, 128'(n), 128'(LAT));
        if (is_write) begin
            model_mem[idx] = data;
            written_q.push_back(idx);
            model_wr++;
        end else begin
            model_rdata = model_mem[idx];
            model_rd++;
        end
        check({tag, "_rdata_ready"}, mem_rdata, model_rdata);
        tick();
        check({tag, "_hold_ready"}, 128'(mem_ready), 128'(0));
        check({tag, "_rdata_hold"}, mem_rdata, model_rdata);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check({tag, "_idle_ready"}, 128'(mem_ready), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] old7;
        logic [27:0]  a;
        int           pick;

        model_rdata  = 128'd0;
        model_rd     = 0;
        model_wr     = 0;
        proc_reset_n = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 28'd0;
        mem_wdata    = 128'd0;

        // Reset state.
        tick();
        tick();
        check("reset_ready", 128'(mem_ready), 128'(0));
        check("reset_rdata", mem_rdata, 128'd0);
        check("reset_proto", 128'(proto_err), 128'(0));
        check_counters("reset");
        proc_reset_n = 1'b1;
        tick();

        // Basic write then read, same index; read held through HOLD.
        xact(1'b1, 28'h0000005, 128'h0123456789ABCDEF_00000000DEADBEEF, "wr5");
        xact(1'b0, 28'h0000005, 128'd0, "rd5");
        idle_watch(LAT + 2, "after_rd5");

        // Alias: upper address bits ignored.
        xact(1'b0, 28'h0000405, 128'd0, "rd405_alias");

        // Both request lines high while idle.
        mem_addr  = 28'h0000009;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        idle_watch(LAT + 3, "both_high");
        check("proto_set", 128'(proto_err), 128'(1));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();

        // Abort: read request dropped in the second BUSY cycle.
        xact(1'b1, 28'h0000020, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, "wr20");
        mem_addr = 28'h0000020;
        mem_read = 1'b1;
        tick();
        tick();
        mem_read = 1'b0;
        idle_watch(LAT + 2, "abort");
        check("abort_rdata", mem_rdata, model_rdata);
        check_counters("abort");
        xact(1'b0, 28'h0000020, 128'd0, "rd20_after_abort");
        check("proto_sticky", 128'(proto_err), 128'(1));

        // Randomized back-to-back traffic with aliasing upper bits.
        for (int t = 0; t < 40; t++) begin
            a = 28'($urandom);
            if (($urandom_range(0, 1) == 0) || (written_q.size() == 0)) begin
                a[IDXW-1:0] = IDXW'($urandom_range(0, 31));
                xact(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, "rnd_wr");
            end else begin
                pick = written_q[$urandom_range(0, written_q.size() - 1)];
                a[IDXW-1:0] = IDXW'(pick);
                xact(1'b0, a, 128'd0, "rnd_rd");
            end
        end
        check_counters("random");

        // Reset during BUSY of a write to index 7: nothing commits.
        old7 = 128'h11112222_33334444_55556666_77778888;
        xact(1'b1, 28'h0000007, old7, "wr7_a");
        mem_addr  = 28'h0000007;
        mem_wdata = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
        mem_write = 1'b1;
        tick();
        tick();
        #2;
        proc_reset_n = 1'b0;
        #1;
        model_rdata = 128'd0;
        model_rd    = 0;
        model_wr    = 0;
        check("rst_busy_ready", 128'(mem_ready), 128'(0));
        check("rst_busy_rdata", mem_rdata, 128'd0);
        check("rst_busy_proto", 128'(proto_err), 128'(0));
        check_counters("rst_busy");
        mem_write = 1'b0;
        tick();
        proc_reset_n = 1'b1;
        tick();
        xact(1'b0, 28'h0000007, 128'd0, "rd7_after_reset");
        check("proto_after_reset", 128'(proto_err), 128'(0));

        // Counter check: 3 reads + 2 writes from a clean reset.
        proc_reset_n = 1'b0;
        tick();
        proc_reset_n = 1'b1;
        model_rdata = 128'd0;
        model_rd    = 0;
        model_wr    = 0;
        tick();
        xact(1'b1, 28'h0000030, 128'h0000000000000000_00000000CAFEF00D, "cnt_wr1");
        xact(1'b0, 28'h0000030, 128'd0, "cnt_rd1");
        xact(1'b1, 28'h0000031, 128'h0000000000000000_0000000012345678, "cnt_wr2");
        xact(1'b0, 28'h0000031, 128'd0, "cnt_rd2");
        xact(1'b0, 28'h0000030, 128'd0, "cnt_rd3");
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Line-granular main-memory responder that sits on the memory side of the L2 data cache and serves its `mem_read`/`mem_write` requests. It holds a backing store of 128-bit lines and answers each request after a fixed, parameterised latency with a one-cycle `mem_ready` pulse. It is shaped so that the cache's registered sampling of `mem_ready` completes cleanly: read data stays stable and the request is not re-accepted during the cycle after the pulse.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `mem_ready`; must be ≥1.
- `IDX_W`, 10: backing-store index width; depth is 2^IDX_W lines.
- `clk`  in  1  clock, rising edge.
- `proc_reset_n`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  read request, held until completion.
- `mem_write`  in  1  write request, held until completion.
- `mem_addr`  in  28  line address; bits [IDX_W-1:0] index the store, upper bits ignored (aliasing).
- `mem_wdata`  in  128  write line.
- `mem_rdata`  out  128  read line.
- `mem_ready`  out  1  one-cycle completion pulse.
- `proto_err`  out  1  sticky; set when `mem_read` and `mem_write` are seen high together in IDLE.
- `rd_cnt`, `wr_cnt`  out  32 each  completed-transaction counters; present only with `L2_MEM_RESP_STATS_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE, HOLD.
- **IDLE**
  - Exactly one of read/write high: latch op, address index and wdata; load the counter with LATENCY-1.
    - LATENCY=1: go to DONE.
    - Otherwise: go to BUSY.
  - Both high: stay IDLE, set `proto_err`.
  - Neither high: stay IDLE.
- **BUSY**
  - Decrement the counter; go to DONE when it reaches 0.
  - If the latched op's request line drops: abort to IDLE, with no write and no pulse.
- **DONE**
  - `mem_ready`=1.
  - Read: `mem_rdata` = store[idx].
  - Write: store[idx] ← latched wdata at the closing edge.
  - Go to HOLD unconditionally.
- **HOLD**
  - `mem_ready`=0; `mem_rdata` keeps its DONE value.
  - Request inputs are ignored, since the cache still drives them this cycle.
  - Go to IDLE.
- `mem_rdata` otherwise holds its last read value; it is not cleared between transactions.
- Latched wdata and address are used, so later input changes do not corrupt a write in flight.
- Backing store is not reset.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, counters 0.
- Reset is asynchronous; a transaction interrupted before its DONE edge commits nothing.
- Request high in cycle T (state IDLE) → `mem_ready` high in cycle T+LATENCY.
- `mem_rdata` is valid in cycles T+LATENCY and T+LATENCY+1.
- Earliest next acceptance is cycle T+LATENCY+2.
- Back-to-back throughput: one line per LATENCY+2 cycles.
- Write then read of the same index back-to-back returns the new data.
- Counters increment at the DONE edge and wrap at 2^32.

## Configuration
- `L2_MEM_RESP_STATS_EN` defined: `rd_cnt`/`wr_cnt` ports and their registers exist; they count completed reads/writes and exclude aborts.
- Undefined: ports and logic are absent; all other behaviour is identical.

## Structure
- Package `l2_mem_resp_pkg`:
  - `LINE_W`=128, `ADDR_W`=28.
  - FSM state enum.
  - Counter width function of LATENCY.
- Sub-module `l2_mem_resp_ram`: 2^IDX_W×128 single-port synchronous array with write enable, index and wdata inputs and registered read. The FSM's DONE timing accounts for the one-cycle read latency: the read is issued when BUSY's final cycle is reached, or on acceptance when LATENCY=1.

## Test plan
- Reset, then write 0x…DEADBEEF to addr 0x0000005, LATENCY=4 → `mem_ready` 4 cycles after the request; read of 0x0000005 returns 0x…DEADBEEF for 2 cycles.
- Request held through HOLD (cache-style release one cycle after `mem_ready`) → exactly one pulse and no second transaction.
- Read 0x0000405 with IDX_W=10 after writing 0x0000005 → same data (alias).
- `mem_read`=`mem_write`=1 in IDLE → no `mem_ready`; `proto_err`=1 and stays set until reset.
- Read request dropped in 2nd BUSY cycle → return to IDLE, no pulse, `rd_cnt` unchanged.
- `proc_reset_n` low during BUSY of a write to 0x0000007 → outputs zero immediately and the store at 7 is unchanged. With the macro, 3 reads + 2 writes → `rd_cnt`=3, `wr_cnt`=2.
